// File: rtl/uart_transmitter.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Each bit lasts `prescale` clocks (clamped to a minimum of 2); all outputs are registered.
module uart_transmitter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic [5:0]            prescale,
  output logic                  serial_data_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            presc_q, presc_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [5:0] presc_clamped;
  logic       bit_end;

  assign presc_clamped = (prescale < 6'd2) ? 6'd2 : prescale;
  assign bit_end       = (cnt_q == (presc_q - 6'd1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    bit_d    = bit_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    tx_d     = 1'b1;
    busy_d   = 1'b1;
    done_d   = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
    end

    // tx_d always reflects the bit that will be on the line in the next cycle
    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        bit_d  = '0;
        if (data_valid) begin
          state_d  = StStart;
          data_d   = parallel_data;
          presc_d  = presc_clamped;
          par_en_d = parity_enable;
          par_d    = (^parallel_data) ^ parity_type;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = StData;
          tx_d    = data_q[0];
        end
      end
      StData: begin
        tx_d = data_q[0];
        if (bit_end) begin
          if (bit_q == LastBit) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d  = bit_q + BitW'(1);
            data_d = data_q >> 1;
            tx_d   = data_q[1];
          end
        end
      end
      StParity: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      presc_q  <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign serial_data_out = tx_q;
  assign busy            = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: requests push expected frames, a line monitor
// pops them and checks every line cycle, busy, and the tx_done pulse.
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic [7:0] parallel_data;
  logic       data_valid;
  logic       parity_enable;
  logic       parity_type;
  logic [5:0] prescale;
  logic       serial_data_out;
  logic       busy;
  logic       tx_done;

  uart_transmitter #(
    .DATA_WIDTH(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .parallel_data  (parallel_data),
    .data_valid     (data_valid),
    .parity_enable  (parity_enable),
    .parity_type    (parity_type),
    .prescale       (prescale),
    .serial_data_out(serial_data_out),
    .busy           (busy),
    .tx_done        (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         par;
    int         p;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   just_done = 1'b0;
  int   cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] ps);
    exp_t e;
    @(negedge clk);
    parallel_data = d;
    parity_enable = pe;
    parity_type   = pt;
    prescale      = ps;
    data_valid    = 1'b1;
    e.d   = d;
    e.pe  = pe;
    e.par = pt ^ ($countones(d) % 2 == 1);
    e.p   = (ps < 2) ? 2 : int'(ps);
    sb.push_back(e);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Counts negedges until tx_done is seen high.
  task automatic wait_done(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (tx_done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("timeout_tx_done", 32'd0, 32'd1);
  endtask

  // Called on the first low sample of a frame; consumes the frame and the done cycle.
  task automatic run_frame(input exp_t e);
    int         total, nbits, glitches, busy_bad, b;
    logic [11:0] exp_bits, obs_bits;
    bit         aborted;
    nbits    = 10 + (e.pe ? 1 : 0);
    total    = nbits * e.p;
    exp_bits = '1;
    obs_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = e.d[i];
    if (e.pe) exp_bits[9] = e.par;
    glitches = 0;
    busy_bad = 0;
    aborted  = 1'b0;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      if (!reset) begin
        aborted = 1'b1;
        break;
      end
      b = c / e.p;
      if (c % e.p == e.p / 2) obs_bits[b] = serial_data_out;
      if (serial_data_out !== exp_bits[b]) glitches++;
      if (busy !== 1'b1 || tx_done !== 1'b0) busy_bad++;
    end
    if (!aborted) begin
      check($sformatf("frame_bits_%02h", e.d), 32'(obs_bits), 32'(exp_bits));
      check($sformatf("bit_timing_%02h", e.d), glitches, 0);
      check($sformatf("busy_in_frame_%02h", e.d), busy_bad, 0);
      @(negedge clk);
      check($sformatf("frame_end_%02h", e.d), {29'd0, tx_done, busy, serial_data_out}, 32'b101);
      just_done = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (just_done) begin
        check("done_one_cycle", 32'(tx_done), 32'd0);
        just_done = 1'b0;
      end
      if (reset === 1'b1 && serial_data_out === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          run_frame(e);
        end
      end
    end
  end

  initial begin : stim
    int viol;
    reset         = 1'b0;
    parallel_data = '0;
    data_valid    = 1'b0;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    prescale      = 6'd8;
    repeat (3) @(negedge clk);
    check("rst_line", 32'(serial_data_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    reset = 1'b1;

    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (serial_data_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) viol++;
    end
    check("idle_quiet", viol, 0);

    send(8'hA5, 1'b0, 1'b0, 6'd8);
    wait_done(200, cyc);
    check("len_8n1_p8", cyc, 80);

    send(8'hA5, 1'b1, 1'b0, 6'd16);
    wait_done(400, cyc);
    check("len_8e1_p16", cyc, 176);
    send(8'hA5, 1'b1, 1'b1, 6'd16);
    wait_done(400, cyc);
    send(8'h01, 1'b1, 1'b0, 6'd16);
    wait_done(400, cyc);

    // Back-to-back: data_valid held high across the frame boundary
    @(negedge clk);
    parallel_data = 8'h3C;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    prescale      = 6'd8;
    data_valid    = 1'b1;
    sb.push_back('{d: 8'h3C, pe: 1'b0, par: 1'b0, p: 8});
    @(negedge clk);
    parallel_data = 8'hC3;
    sb.push_back('{d: 8'hC3, pe: 1'b0, par: 1'b0, p: 8});
    wait_done(200, cyc);
    @(negedge clk);
    check("b2b_start", 32'(serial_data_out), 32'd0);
    data_valid = 1'b0;
    repeat (20) @(negedge clk);
    parallel_data = 8'hFF;
    data_valid    = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_done(200, cyc);

    // Inputs disturbed during the data bits must not alter the frame
    send(8'h96, 1'b0, 1'b0, 6'd8);
    repeat (28) @(negedge clk);
    parallel_data = 8'h00;
    parity_enable = 1'b1;
    parity_type   = 1'b1;
    prescale      = 6'd3;
    wait_done(200, cyc);

    // Reset during the data bits aborts the frame
    send(8'h5A, 1'b0, 1'b0, 6'd8);
    repeat (30) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_line_high", 32'(serial_data_out), 32'd1);
    check("abort_busy_low", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || serial_data_out !== 1'b1) viol++;
    end
    check("abort_no_done", viol, 0);
    send(8'h5A, 1'b0, 1'b0, 6'd8);
    wait_done(200, cyc);
    check("len_after_abort", cyc, 80);

    send(8'h5A, 1'b0, 1'b0, 6'd0);
    wait_done(100, cyc);
    check("len_p0", cyc, 20);
    send(8'h69, 1'b1, 1'b1, 6'd1);
    wait_done(100, cyc);
    check("len_p1_parity", cyc, 22);
    send(8'hFF, 1'b1, 1'b0, 6'd63);
    wait_done(1000, cyc);
    check("len_p63_parity", cyc, 693);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
